// File: rtl/exec_ctrl_seq.sv
// Multi-cycle ALU/FP control sequencer: decodes ALUOp/funct7/funct3 into a control
// code, holds it for a class-dependent latency, then presents it on a valid/ready port.
module exec_ctrl_seq #(
    parameter int CTL_W     = 5,
    parameter int LAT_INT   = 1,
    parameter int LAT_FADD  = 3,
    parameter int LAT_FMUL  = 4,
    parameter int LAT_FDIV  = 12,
    parameter int LAT_FSQRT = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTL_W-1:0] alu_ctl,
    output logic             illegal_op,
    output logic             fu_start,
    output logic             fu_busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] CTL_NOP = 5'b11111;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CTL_W-1:0]   alu_ctl_q;
    logic               illegal_q;
    logic               out_valid_q;
    logic               fu_start_q;
    logic               fu_busy_q;

    logic [4:0]         ctl_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               fp_long_d;
    logic               accept;

    // Handshake: an op is taken when in_valid && in_ready at a rising edge; a result is
    // consumed when out_valid && out_ready at a rising edge. Flush blocks acceptance.
    assign in_ready = !flush && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        ctl_d = CTL_NOP;
        case (alu_op)
            2'b00: begin
                if (funct3 == 3'b000)      ctl_d = 5'b00000;
                else if (funct3 == 3'b010) ctl_d = 5'b01000;
            end
            2'b01: ctl_d = 5'b01010;
            2'b10: begin
                case (funct3)
                    3'b000:  ctl_d = funct7[5] ? 5'b00010 : 5'b00000;
                    3'b001:  ctl_d = 5'b00101;
                    3'b010:  ctl_d = 5'b01000;
                    3'b011:  ctl_d = 5'b01001;
                    3'b100:  ctl_d = 5'b00100;
                    3'b101:  ctl_d = funct7[5] ? 5'b00111 : 5'b00110;
                    3'b110:  ctl_d = 5'b00011;
                    default: ctl_d = 5'b00001;
                endcase
            end
            default: begin
                case (funct7)
                    7'b0000000: ctl_d = 5'b10000;
                    7'b0000100: ctl_d = 5'b10001;
                    7'b0001000: ctl_d = 5'b10010;
                    7'b0001100: ctl_d = 5'b10011;
                    7'b0101100: ctl_d = 5'b10100;
                    7'b0010000: begin
                        if (funct3 == 3'b000)      ctl_d = 5'b10101;
                        else if (funct3 == 3'b001) ctl_d = 5'b10110;
                        else if (funct3 == 3'b010) ctl_d = 5'b10111;
                    end
                    default: ctl_d = CTL_NOP;
                endcase
            end
        endcase
    end

    // The counter is loaded with latency-1 so EXEC lasts exactly the op latency.
    always_comb begin
        cnt_d = CNT_W'(LAT_INT - 1);
        case (ctl_d)
            5'b10000, 5'b10001: cnt_d = CNT_W'(LAT_FADD - 1);
            5'b10010:           cnt_d = CNT_W'(LAT_FMUL - 1);
            5'b10011:           cnt_d = CNT_W'(LAT_FDIV - 1);
            5'b10100:           cnt_d = CNT_W'(LAT_FSQRT - 1);
            default:            cnt_d = CNT_W'(LAT_INT - 1);
        endcase
        fp_long_d = (ctl_d >= 5'b10000) && (ctl_d <= 5'b10100) && (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_ctl_q   <= CTL_W'(CTL_NOP);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            fu_start_q  <= 1'b0;
            fu_busy_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            fu_start_q  <= 1'b0;
            fu_busy_q   <= 1'b0;
        end else begin
            fu_start_q <= 1'b0;
            if (accept) begin
                state_q     <= S_EXEC;
                cnt_q       <= cnt_d;
                alu_ctl_q   <= CTL_W'(ctl_d);
                illegal_q   <= (ctl_d == CTL_NOP);
                out_valid_q <= 1'b0;
                fu_start_q  <= fp_long_d;
                fu_busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_EXEC: begin
                        if (cnt_q == '0) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            fu_busy_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (out_ready) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A flush landing on the start cycle must not launch the FP unit.
    assign fu_start   = fu_start_q && !flush;
    assign out_valid  = out_valid_q;
    assign alu_ctl    = alu_ctl_q;
    assign illegal_op = illegal_q;
    assign fu_busy    = fu_busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_exec_ctrl_seq.sv
// Bench for exec_ctrl_seq: directed scenarios then random traffic, checked against a
// table-driven reference of the decode/latency rules through an expected-result queue.
module tb_exec_ctrl_seq;

    localparam int CTL_W     = 5;
    localparam int LAT_INT   = 1;
    localparam int LAT_FADD  = 3;
    localparam int LAT_FMUL  = 4;
    localparam int LAT_FDIV  = 12;
    localparam int LAT_FSQRT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       alu_op = '0;
    logic [6:0]       funct7 = '0;
    logic [2:0]       funct3 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CTL_W-1:0] alu_ctl;
    logic             illegal_op;
    logic             fu_start;
    logic             fu_busy;
    logic [1:0]       dbg_state;

    exec_ctrl_seq #(
        .CTL_W(CTL_W), .LAT_INT(LAT_INT), .LAT_FADD(LAT_FADD), .LAT_FMUL(LAT_FMUL),
        .LAT_FDIV(LAT_FDIV), .LAT_FSQRT(LAT_FSQRT), .CNT_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .out_valid(out_valid),
        .out_ready(out_ready), .alu_ctl(alu_ctl), .illegal_op(illegal_op),
        .fu_start(fu_start), .fu_busy(fu_busy), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int or_mode = 1;   // 0 random, 1 always ready, 2 never ready

    logic [5:0] exp_q[$];   // {illegal, ctl}
    bit         have_op = 0;
    int         acc_cyc = 0;
    int         due = 0;
    bit         start_exp = 0;
    bit         seen = 0;
    logic [5:0] held = '0;
    bit         s_fl = 0, s_hs = 0, s_acc = 0;
    logic [4:0] s_ctl = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decode, written straight from the instruction tables
    function automatic logic [4:0] ref_ctl(input logic [1:0] op, input logic [6:0] f7,
                                           input logic [2:0] f3);
        logic [4:0] r_tab[8];
        logic [6:0] fp_f7[5];
        logic [4:0] r;
        r_tab = '{5'b00000, 5'b00101, 5'b01000, 5'b01001,
                  5'b00100, 5'b00110, 5'b00011, 5'b00001};
        fp_f7 = '{7'd0, 7'd4, 7'd8, 7'd12, 7'd44};
        r = 5'b11111;
        if (op == 2'b00) begin
            if (f3 == 3'd0) r = 5'b00000;
            if (f3 == 3'd2) r = 5'b01000;
        end else if (op == 2'b01) begin
            r = 5'b01010;
        end else if (op == 2'b10) begin
            r = r_tab[f3];
            if (f7[5] && f3 == 3'd0) r = 5'b00010;
            if (f7[5] && f3 == 3'd5) r = 5'b00111;
        end else begin
            for (int i = 0; i < 5; i++)
                if (f7 == fp_f7[i]) r = 5'd16 + 5'(i);
            if (f7 == 7'b0010000 && f3 <= 3'd2) r = 5'd21 + 5'(f3);
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] c);
        if (c == 5'd16 || c == 5'd17) return LAT_FADD;
        if (c == 5'd18) return LAT_FMUL;
        if (c == 5'd19) return LAT_FDIV;
        if (c == 5'd20) return LAT_FSQRT;
        return LAT_INT;
    endfunction

    // Monitor: samples mid-cycle, compares against the model and pops results
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_alu_ctl", alu_ctl, 5'b11111);
            check("rst_illegal", illegal_op, 0);
            check("rst_fu_start", fu_start, 0);
            check("rst_fu_busy", fu_busy, 0);
            s_fl = 0; s_hs = 0; s_acc = 0;
        end else begin
            check("out_valid", out_valid, have_op && cyc >= due);
            check("fu_busy", fu_busy, have_op && cyc < due);
            check("fu_start", fu_start, have_op && cyc == acc_cyc && start_exp && !flush);
            check("in_ready", in_ready,
                  !flush && (!have_op || (cyc >= due && out_ready)));
            if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        held = exp_q.pop_front();
                        check("alu_ctl", alu_ctl, held[4:0]);
                        check("illegal_op", illegal_op, held[5]);
                    end
                    seen = 1;
                end else begin
                    check("hold_alu_ctl", alu_ctl, held[4:0]);
                    check("hold_illegal", illegal_op, held[5]);
                end
            end
            s_fl  = flush;
            s_hs  = out_valid && out_ready;
            s_acc = in_valid && in_ready;
            s_ctl = ref_ctl(alu_op, funct7, funct3);
        end
    end

    // Model update at each edge: handshake, accept and flush effects
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (s_fl) begin
                have_op = 0; seen = 0; exp_q.delete();
            end else begin
                if (s_hs) begin have_op = 0; seen = 0; end
                if (s_acc) begin
                    exp_q.push_back({s_ctl == 5'b11111, s_ctl});
                    have_op   = 1;
                    acc_cyc   = cyc;
                    due       = cyc + ref_lat(s_ctl);
                    start_exp = (s_ctl >= 5'd16) && (s_ctl <= 5'd20) && (ref_lat(s_ctl) > 1);
                end
            end
        end
        s_fl = 0; s_hs = 0; s_acc = 0;
    end

    always @(posedge clk) begin
        #2;
        if (or_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else              out_ready = (or_mode == 1);
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        bit got = 0;
        alu_op = op; funct7 = f7; funct3 = f3; in_valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            done = !have_op && exp_q.size() == 0;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        logic [6:0] fp_pick[6];
        logic [1:0] op;
        logic [6:0] f7;
        int r;
        fp_pick = '{7'd0, 7'd4, 7'd8, 7'd12, 7'd44, 7'd16};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(2'b10, 7'b0100000, 3'b000);          // SUB
        wait_idle();

        or_mode = 2;                              // FDIV with stalled consumer
        send(2'b11, 7'b0001100, 3'b000);
        for (int i = 0; i < 40 && !out_valid; i++) step();
        repeat (5) step();
        or_mode = 1;
        wait_idle();

        send(2'b11, 7'b0000000, 3'b000);          // FADD then ADD back to back
        send(2'b10, 7'b0000000, 3'b000);
        wait_idle();

        send(2'b11, 7'b0010000, 3'b011);          // illegal FSGNJ variant
        wait_idle();

        send(2'b11, 7'b0101100, 3'b000);          // FSQRT aborted by flush
        repeat (6) step();
        pulse_flush();
        send(2'b10, 7'b0000000, 3'b010);          // SLT
        wait_idle();

        send(2'b11, 7'b0001000, 3'b000);          // FMUL aborted by reset
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_alu_ctl", alu_ctl, 5'b11111);
        check("async_rst_fu_busy", fu_busy, 0);
        check("async_rst_illegal", illegal_op, 0);
        have_op = 0; seen = 0; exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(2'b00, 7'b0000000, 3'b000);          // ADDI
        wait_idle();

        or_mode = 0;
        for (int n = 0; n < 200; n++) begin
            op = 2'($urandom_range(0, 3));
            f7 = 7'($urandom_range(0, 127));
            if (op == 2'b11 && $urandom_range(0, 4) != 0) f7 = fp_pick[$urandom_range(0, 5)];
            send(op, f7, 3'($urandom_range(0, 7)));
            r = $urandom_range(0, 9);
            if (r == 0) pulse_flush();
            if (r == 1) begin
                repeat ($urandom_range(1, 6)) step();
                pulse_flush();
            end
            repeat ($urandom_range(0, 2)) step();
        end

        or_mode = 1;
        wait_idle();
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
